spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning: SCLK half-period in clk cycles; legal range 4..255.
REQ-002 Parameter GAP_CYCLES, default 8, meaning: minimum nCS-high clk cycles between frames; legal range 1..255.
REQ-003 clk  input  1  system clock; the single clock of the block, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_addr  input  7  target register address.
REQ-008 cmd_data  input  8  register write data.
REQ-009 sclk  output  1  SPI serial clock, mode 0.
REQ-010 ncs  output  1  SPI chip select, active-low.
REQ-011 copi  output  1  SPI serial data, controller to peripheral.
REQ-012 busy  output  1  high from command accept until return to IDLE.
REQ-013 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-014 Frame SHALL be 16 bits, MSB first: bit15 = 1 (write), bits14:8 = cmd_addr, bits7:0 = cmd_data.
REQ-015 FSM states SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP; every state drives its outputs from registers (no combinational path from cmd_* to SPI pins).
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready, with cmd_addr/cmd_data latched in that cycle.
REQ-017 IDLE: ncs=1, sclk=0, copi=0, busy=0.
REQ-018 Accept -> SETUP on the next cycle: ncs=0, sclk=0, copi=frame bit15, duration CLK_DIV cycles.
REQ-019 SETUP -> SHIFT_HI: sclk=1 for CLK_DIV cycles, copi stable.
REQ-020 SHIFT_HI -> SHIFT_LO: sclk=0 for CLK_DIV cycles; copi updates to the next bit on entry to SHIFT_LO (falling edge).
REQ-021 4-bit bit counter SHALL increment at each SHIFT_HI exit; after the 16th SHIFT_HI, SHIFT_LO serves as nCS hold (copi=0) and then exits to GAP.
REQ-022 ncs SHALL stay low exactly 33*CLK_DIV cycles per frame (132 at default); exactly 16 sclk rising edges per frame.
REQ-023 GAP: ncs=1, sclk=0, busy=1, for GAP_CYCLES cycles, then IDLE; done SHALL pulse high for the first GAP cycle only.
REQ-024 cmd_valid held high during busy SHALL be ignored; no command is queued; a new command is accepted only in IDLE.
REQ-025 Back-to-back: with cmd_valid held, the next accept occurs on the first IDLE cycle, giving nCS-high time of GAP_CYCLES+1 cycles.
REQ-026 Changes on cmd_addr/cmd_data after accept SHALL NOT affect the frame in progress.
REQ-027 Divider counter SHALL be width 8 and reload to CLK_DIV-1 on every state change; no wrap-around beyond CLK_DIV.
REQ-028 Out-of-range CLK_DIV or GAP_CYCLES SHALL cause an elaboration-time error.

Reset
REQ-029 While rst_n=0 at a clk edge: state=IDLE, ncs=1, sclk=0, copi=0, busy=0, done=0, counters=0, latched frame=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame at the next clk edge with ncs=1 and no done pulse; the partial frame is discarded.
REQ-031 cmd_ready SHALL be 0 during any cycle with rst_n=0 and 1 on the first cycle after release.

Structure
REQ-032 Shared package spi_pkg SHALL hold FRAME_BITS=16, WRITE_BIT=1, FSM state typedef, and register address constants: EN_OUT_7_0=0x00, EN_OUT_15_8=0x01, EN_PWM_7_0=0x02, EN_PWM_15_8=0x03, PWM_DUTY=0x04.
REQ-033 One sub-module spi_clk_div SHALL generate the half-period tick (load, tick outputs); shift register and FSM stay in spi_controller.

Verification
REQ-034 Write addr 0x04 data 0x80 at CLK_DIV=4 -> copi sampled on sclk rising edges = 0x8480, ncs low 132 cycles, one done pulse.
REQ-035 Back-to-back writes (0x00,0xFF) then (0x01,0x0F), cmd_valid held -> two frames 0x80FF, 0x810F, ncs high 9 cycles between.
REQ-036 rst_n low at 8th sclk rising edge of a frame -> ncs=1, sclk=0 next cycle, no done, next command sends a full correct frame.
REQ-037 cmd_valid pulsed at cycles 10 and 50 after a first accept -> both ignored, exactly one frame sent, cmd_ready=0 throughout busy.
REQ-038 Loopback to spi_peripheral, writes to 0x00..0x04 with 0xA5,0x5A,0x3C,0xC3,0x7F -> all five peripheral registers read back those values.
REQ-039 CLK_DIV=8, GAP_CYCLES=1 -> ncs low 264 cycles, sclk period 16 cycles, ncs high 2 cycles between back-to-back frames.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI write-frame definitions: frame layout, FSM states and peripheral register map.
package spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam logic WRITE_BIT = 1'b1;

  localparam logic [6:0] EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [6:0] addr, input logic [7:0] data);
    return {WRITE_BIT, addr, data};
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: load restarts a CLK_DIV-cycle interval, tick marks its last cycle.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= 8'(CLK_DIV - 1);
    else if (cnt != '0)  cnt <= cnt - 8'd1;
  end

  assign tick = (cnt == '0);
endmodule

// File: rtl/spi_controller.sv
// Write-only SPI mode-0 controller: one 16-bit frame per accepted command, then an nCS gap.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  output logic       busy,
  output logic       done
);
  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be 4..255");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("spi_controller: GAP_CYCLES must be 1..255");
  end

  state_t                state;
  logic [FRAME_BITS-1:0] frame, shreg;
  logic [3:0]            bit_cnt;
  logic                  last;
  logic [7:0]            gap_cnt;
  logic                  tick, load, accept;

  assign frame     = make_frame(cmd_addr, cmd_data);
  assign cmd_ready = rst_n && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Every state change restarts the half-period timer.
  assign load = accept
             || (tick && (state == SETUP || state == SHIFT_HI || state == SHIFT_LO))
             || (state == GAP && gap_cnt == '0);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ncs     <= 1'b1;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      last    <= 1'b0;
      gap_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          // shreg holds the bits still to be sent, next one at the MSB
          copi    <= frame[FRAME_BITS-1];
          shreg   <= {frame[FRAME_BITS-2:0], 1'b0};
          ncs     <= 1'b0;
          busy    <= 1'b1;
          bit_cnt <= '0;
          last    <= 1'b0;
          state   <= SETUP;
        end
        SETUP: if (tick) begin
          sclk  <= 1'b1;
          state <= SHIFT_HI;
        end
        SHIFT_HI: if (tick) begin
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 4'd1;
          state   <= SHIFT_LO;
          if (bit_cnt == 4'(FRAME_BITS - 1)) begin
            last <= 1'b1;
            copi <= 1'b0;
          end else begin
            copi  <= shreg[FRAME_BITS-1];
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
          end
        end
        SHIFT_LO: if (tick) begin
          if (last) begin
            ncs     <= 1'b1;
            done    <= 1'b1;
            gap_cnt <= 8'(GAP_CYCLES - 1);
            state   <= GAP;
          end else begin
            sclk  <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// Random and directed stimulus against a cycle-count reference of the SPI write frame.
module tb_spi_controller;
  import spi_pkg::*;
  localparam int CD  = 4;
  localparam int GP  = 8;
  localparam int LOW = 33 * CD;

  logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, sclk, ncs, copi, busy, done;

  spi_controller #(.CLK_DIV(CD), .GAP_CYCLES(GP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sclk(sclk), .ncs(ncs),
    .copi(copi), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: cycles remaining until IDLE after an accept; pins follow from elapsed time.
  int          left = 0, n_acc = 0;
  bit          armed = 0;
  logic [15:0] m_frame = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      left  = 0;
      armed = 1;
    end else if (left == 0) begin
      if (cmd_valid) begin
        m_frame = {1'b1, cmd_addr, cmd_data};
        left    = LOW + GP;
        n_acc++;
      end
    end else begin
      left--;
    end
  end

  // Pin monitor plus a behavioural peripheral that latches on nCS rise.
  logic [7:0]  preg [0:127];
  logic [15:0] cap = '0;
  int          bits = 0, rises = 0, hi_run = 0, lo_run = 0, exp_gap = 0, ph, h, ebit;
  logic        psclk = 1'b0, pncs = 1'b1;
  bit          ib;

  always @(negedge clk) if (armed) begin
    ib = (left > 0);
    chk("busy",  32'(busy),      32'(ib));
    chk("ready", 32'(cmd_ready), 32'(rst_n && !ib));
    chk("ncs",   32'(ncs),       32'(!(left > GP)));
    chk("done",  32'(done),      32'(left == GP));
    if (left > GP) begin
      ph   = LOW + GP - left;
      h    = ph / CD;
      ebit = (h >= 32) ? 0 : int'(m_frame[15 - h / 2]);
      chk("sclk", 32'(sclk), 32'(h % 2));
      chk("copi", 32'(copi), 32'(ebit));
    end else begin
      chk("sclk_idle", 32'(sclk), 32'd0);
      chk("copi_idle", 32'(copi), 32'd0);
    end
    if (!ncs && sclk && !psclk) begin
      cap = {cap[14:0], copi};
      bits++;
      rises++;
    end
    if (left == GP) begin
      chk("frame_bits", 32'(bits), 32'd16);
      chk("frame",      32'(cap),  32'(m_frame));
    end
    if (ncs && !pncs) begin
      if (left == GP) chk("ncs_low_len", 32'(lo_run), 32'(LOW));
      if (bits == 16) preg[cap[14:8]] = cap[7:0];
    end
    if (!ncs && pncs && exp_gap != 0) chk("ncs_gap", 32'(hi_run), 32'(exp_gap));
    if (ncs) begin
      bits = 0; cap = '0; hi_run++; lo_run = 0;
    end else begin
      hi_run = 0; lo_run++;
    end
    psclk = sclk;
    pncs  = ncs;
  end

  task automatic send(input logic [6:0] a, input logic [7:0] d, input bit drop);
    int start = n_acc;
    int t = 0;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (n_acc == start && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("accept", 32'(n_acc - start), 32'd1);
    if (drop) cmd_valid = 1'b0;
    cmd_addr = 7'($urandom);
    cmd_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (left != 0 && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("idle_timeout", 32'(left), 32'd0);
  endtask

  task automatic pulse_valid();
    cmd_addr  = 7'($urandom);
    cmd_data  = 8'($urandom);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  logic [7:0] vals [0:4];
  int a0, r0, t;

  initial begin
    vals[0] = 8'hA5; vals[1] = 8'h5A; vals[2] = 8'h3C; vals[3] = 8'hC3; vals[4] = 8'h7F;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(PWM_DUTY, 8'h80, 1);
    wait_idle();

    // back-to-back with valid held; bus values change right after accept
    send(EN_OUT_7_0, 8'hFF, 0);
    @(negedge clk); #1;
    exp_gap = GP + 1;
    send(EN_OUT_15_8, 8'h0F, 1);
    wait_idle();
    exp_gap = 0;

    // stray requests while busy are dropped
    a0 = n_acc;
    send(7'($urandom), 8'($urandom), 1);
    repeat (9) @(posedge clk);
    #1 pulse_valid();
    repeat (39) @(posedge clk);
    #1 pulse_valid();
    wait_idle();
    chk("single_frame", 32'(n_acc - a0), 32'd1);

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 send(7'($urandom), 8'($urandom), 1'($urandom));
    end
    cmd_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 5; i++) begin
      send(7'(i), vals[i], 1);
      wait_idle();
    end

    // abort a write to 0x02 around the 8th rising edge
    send(EN_PWM_7_0, 8'hEE, 1);
    r0 = rises;
    t  = 0;
    while (rises < r0 + 8 && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("abort_reach", 32'(rises - r0), 32'd8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ncs",  32'(ncs),  32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    @(posedge clk); #1;
    send(7'h10, 8'h96, 1);
    wait_idle();
    repeat (4) @(posedge clk);

    for (int i = 0; i < 5; i++) chk($sformatf("preg%0d", i), 32'(preg[i]), 32'(vals[i]));
    chk("preg10", 32'(preg[16]), 32'h96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
